// File: rtl/lc3b_fetch_ctrl.sv
// lc3b_fetch_ctrl: LC-3b instruction-cycle sequencer (fetch, decode, execute handshake, halt/fault, retire count)
module lc3b_fetch_ctrl #(
  parameter int          MEM_WAIT_MAX = 16,
  parameter logic [7:0]  HALT_VECTOR  = 8'h25
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [15:0] ir_in,
  input  logic        exec_done,
  output logic        gate_pc,
  output logic        ld_mar,
  output logic        ld_pc,
  output logic        mem_en,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        exec_start,
  output logic [3:0]  opcode,
  output logic [15:0] instr_count,
  output logic        halted,
  output logic        fault
);
  typedef enum logic [2:0] {IDLE, F1, F2, F3, DEC, EXEC, HALT, FAULT} state_t;
  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
  state_t     state;
  logic [7:0] wait_cnt;
  logic       is_halt, is_rsvd;
  assign is_halt    = ir_in[15:12] == 4'hF && ir_in[7:0] == HALT_VECTOR;
  assign is_rsvd    = ir_in[15:13] == 3'b101;
  assign gate_pc    = state == F1;
  assign ld_mar     = state == F1;
  assign ld_pc      = state == F1;
  assign mem_en     = state == F2;
  assign ld_mdr     = state == F2 && mem_ready;
  assign ld_ir      = state == F3;
  assign exec_start = state == DEC && !is_halt && !is_rsvd;
  assign halted     = state == HALT;
  assign fault      = state == FAULT;
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      opcode      <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE: state <= run ? F1 : IDLE;
        F1: begin
          wait_cnt <= '0;
          state    <= F2;
        end
        F2: begin
          if (mem_ready) state <= F3;
          else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == WAIT_MAX) state <= FAULT;
          end
        end
        F3: state <= DEC;
        DEC: begin
          opcode <= ir_in[15:12];
          state  <= is_halt ? HALT : is_rsvd ? FAULT : EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            instr_count <= instr_count + 16'd1;
            state       <= run ? F1 : IDLE;
          end
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3b_fetch_ctrl.sv
// tb_lc3b_fetch_ctrl: randomized self-checking bench for lc3b_fetch_ctrl against a cycle-index timing model
module tb_lc3b_fetch_ctrl;
  localparam int WMAX = 4;
  logic        clock_50 = 1'b0, reset_n = 1'b0, run = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
  logic [15:0] ir_in = '0;
  logic        gate_pc, ld_mar, ld_pc, mem_en, ld_mdr, ld_ir, exec_start, halted, fault;
  logic [3:0]  opcode;
  logic [15:0] instr_count;
  int          errors = 0, checks = 0;
  logic [15:0] exp_count = '0;
  logic [3:0]  exp_op = '0;
  logic [6:0]  stb;
  always #5 clock_50 = ~clock_50;
  assign stb = {gate_pc, ld_mar, ld_pc, mem_en, ld_mdr, ld_ir, exec_start};
  lc3b_fetch_ctrl #(.MEM_WAIT_MAX(WMAX), .HALT_VECTOR(8'h25)) dut (
    .clock_50(clock_50), .reset_n(reset_n), .run(run), .mem_ready(mem_ready), .ir_in(ir_in),
    .exec_done(exec_done), .gate_pc(gate_pc), .ld_mar(ld_mar), .ld_pc(ld_pc), .mem_en(mem_en),
    .ld_mdr(ld_mdr), .ld_ir(ld_ir), .exec_start(exec_start), .opcode(opcode),
    .instr_count(instr_count), .halted(halted), .fault(fault)
  );
  function automatic logic [6:0] fetch_stb(int c, int f2_end, logic rdy, logic xs);
    if (c == 0) return 7'b1110000;
    if (c <= f2_end) return {3'b000, 1'b1, rdy, 2'b00};
    if (c == f2_end + 1) return 7'b0000010;
    if (c == f2_end + 2) return {6'b0, xs};
    return 7'b0;
  endfunction
  task automatic cyc(input logic r, input logic m, input logic e, input logic [15:0] ir);
    @(negedge clock_50);
    run = r; mem_ready = m; exec_done = e; ir_in = ir;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clock_50);
    reset_n = 1'b0; run = 1'b0;
    #1;
    @(negedge clock_50);
    reset_n = 1'b1;
    exp_count = '0; exp_op = '0;
  endtask
  task automatic go();
    cyc(1'b1, 1'($urandom), 1'($urandom), 16'($urandom));
    checks++;
    if ({stb, halted, fault} !== 9'b0) begin
      errors++; $display("FAIL idle_start got %b want 0", {stb, halted, fault});
    end
  endtask
  task automatic idle_hold(input int n);
    for (int c = 0; c < n; c++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), 16'($urandom));
      checks++;
      if ({stb, opcode, instr_count, halted, fault} !== {7'b0, exp_op, exp_count, 2'b00}) begin
        errors++;
        $display("FAIL idle_hold c=%0d got %h want %h", c, {stb, opcode, instr_count, halted, fault}, {7'b0, exp_op, exp_count, 2'b00});
      end
    end
  endtask
  task automatic run_instr(input logic [15:0] ir, input int w, input int d, input logic keep);
    logic m, e, r;
    logic [6:0] es;
    logic [3:0] eo;
    for (int c = 0; c <= w + 4 + d; c++) begin
      m  = (c >= 1 && c <= w + 1) ? (c == w + 1) : 1'($urandom);
      e  = (c == w + 4 + d) ? 1'b1 : (c >= w + 4) ? 1'b0 : 1'($urandom);
      r  = (c == w + 4 + d) ? keep : 1'($urandom);
      cyc(r, m, e, ir);
      es = fetch_stb(c, w + 1, m, 1'b1);
      eo = (c > w + 3) ? ir[15:12] : exp_op;
      checks++;
      if ({stb, opcode, instr_count, halted, fault} !== {es, eo, exp_count, 2'b00}) begin
        errors++;
        $display("FAIL instr ir=%h w=%0d c=%0d got %h want %h", ir, w, c, {stb, opcode, instr_count, halted, fault}, {es, eo, exp_count, 2'b00});
      end
    end
    exp_count = exp_count + 16'd1;
    exp_op = ir[15:12];
  endtask
  task automatic run_term(input logic [15:0] ir, input int w, input int kind);
    int f2e, term_at;
    logic m;
    logic [6:0] es;
    logic [3:0] eo;
    f2e = (kind == 2) ? WMAX : w + 1;
    term_at = (kind == 2) ? WMAX + 1 : w + 4;
    go();
    for (int c = 0; c < term_at + 4; c++) begin
      m  = (c >= 1 && c <= f2e) ? (kind != 2 && c == f2e) : 1'($urandom);
      cyc(1'($urandom), m, 1'($urandom), ir);
      es = (c >= term_at) ? 7'b0 : fetch_stb(c, f2e, m, 1'b0);
      eo = (kind != 2 && c > w + 3) ? ir[15:12] : exp_op;
      checks++;
      if ({stb, opcode, instr_count, halted, fault} !== {es, eo, exp_count, kind == 0 && c >= term_at, kind != 0 && c >= term_at}) begin
        errors++;
        $display("FAIL term kind=%0d c=%0d got %h want %h", kind, c, {stb, opcode, instr_count, halted, fault},
                 {es, eo, exp_count, kind == 0 && c >= term_at, kind != 0 && c >= term_at});
      end
    end
  endtask
  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 16'hF025);
    checks++;
    if ({stb, opcode, instr_count, halted, fault} !== 30'b0) begin
      errors++; $display("FAIL reset got %h want 0", {stb, opcode, instr_count, halted, fault});
    end
    @(negedge clock_50);
    reset_n = 1'b1; run = 1'b0;
    idle_hold(2);
  endtask
  task automatic test_basic();
    go();
    run_instr(16'h1234, 0, 0, 1'b1);
  endtask
  task automatic test_wait();
    run_instr(16'h5ABC, 3, 0, 1'b1);
  endtask
  task automatic test_random();
    logic [15:0] ir;
    for (int i = 0; i < 20; i++) begin
      ir = 16'($urandom);
      if (ir[15:13] == 3'b101) ir[15] = 1'b0;
      if (ir[15:12] == 4'hF && ir[7:0] == 8'h25) ir[0] = 1'b0;
      run_instr(ir, int'($urandom_range(0, WMAX - 1)), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask
  task automatic test_run_drop();
    run_instr(16'h6123, 1, 2, 1'b0);
    idle_hold(3);
    go();
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 1'b0, 16'h2000);
    @(negedge clock_50);
    exec_done = 1'b0;
    #1;
    checks++;
    if (instr_count !== exp_count) begin
      errors++; $display("FAIL exec_count got %h want %h", instr_count, exp_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({stb, opcode, instr_count, halted, fault} !== 30'b0) begin
      errors++; $display("FAIL reset_in_exec got %h want 0", {stb, opcode, instr_count, halted, fault});
    end
    exp_count = '0; exp_op = '0;
    @(negedge clock_50);
    reset_n = 1'b1; run = 1'b0;
  endtask
  task automatic test_wrap();
    @(negedge clock_50);
    force dut.instr_count = 16'hFFFF;
    @(negedge clock_50);
    release dut.instr_count;
    exp_count = 16'hFFFF;
    go();
    run_instr(16'h3000, 0, 1, 1'b0);
    idle_hold(2);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_random();
    test_run_drop();
    test_wrap();
    do_reset();
    run_term(16'hF025, 1, 0);
    do_reset();
    run_term(16'hA000, 0, 1);
    do_reset();
    run_term(16'h1111, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc3b_fetch_ctrl.md
# lc3b_fetch_ctrl

Instruction-cycle sequencer for the LC-3b datapath. It drives the PC, MAR, MDR and IR load enables through the fetch sequence, handshakes with memory and with the execute unit, and decodes the opcode from the loaded IR. It detects HALT traps, reserved opcodes and memory timeouts, and keeps a retired-instruction count. It sits between the top-level run control and the datapath registers (PC, MAR, MDR, IR).

## Interface
- MEM_WAIT_MAX, 16: maximum F2 cycles allowed without mem_ready before a fault; legal range 1..255.
- HALT_VECTOR, 8'h25: trap vector treated as HALT.

- clock_50  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 allows new fetches
- mem_ready  in  1  memory read data valid this cycle
- ir_in  in  16  current IR contents
- exec_done  in  1  execute unit finished the current instruction (1-cycle pulse)
- gate_pc  out  1  PC driven onto bus
- ld_mar  out  1  load MAR
- ld_pc  out  1  load PC (PC+2 path)
- mem_en  out  1  memory read request
- ld_mdr  out  1  load MDR
- ld_ir  out  1  load IR from MDR
- exec_start  out  1  1-cycle pulse, execute unit begins
- opcode  out  4  registered ir_in[15:12], captured in DEC
- instr_count  out  16  retired instructions, wraps
- halted  out  1  HALT trap reached
- fault  out  1  reserved opcode or memory timeout

## Operation
- States: IDLE, F1, F2, F3, DEC, EXEC, HALT, FAULT. State, opcode, instr_count and wait counter are registered.
- All strobes are decoded from the current state. ld_mdr also depends on mem_ready.
- IDLE: all strobes 0. Go to F1 when run=1.
- F1: gate_pc=ld_mar=ld_pc=1 (MAR<-PC, PC<-PC+2). Clear the 8-bit wait counter. Go to F2.
- F2: mem_en=1; ld_mdr=mem_ready.
  - mem_ready=1: go to F3.
  - Otherwise: increment the wait counter. When the counter reaches MEM_WAIT_MAX with no ready seen, go to FAULT.
- F3: ld_ir=1. Go to DEC.
- DEC: capture opcode<=ir_in[15:12], then select by priority:
  - ir_in[15:12]=4'b1111 and ir_in[7:0]=HALT_VECTOR: go to HALT. No exec_start.
  - ir_in[15:12] is 4'b1010 or 4'b1011 (reserved): go to FAULT. No exec_start.
  - Otherwise: exec_start=1, go to EXEC.
- EXEC: wait for exec_done. On exec_done, instr_count<=instr_count+1 (mod 2^16). Then go to F1 if run=1, otherwise IDLE.
- HALT: halted=1, all strobes 0. Terminal until reset.
- FAULT: fault=1, all strobes 0. Terminal until reset.
- run is sampled only in IDLE and at exec_done. A deassert mid-instruction lets that instruction finish and retire, then the block goes to IDLE.
- exec_done outside EXEC is ignored.
- mem_ready outside F2 is ignored.

## Timing
- Reset (async assert, any state): state=IDLE, every strobe 0, opcode=0, instr_count=0, halted=0, fault=0, wait counter=0.
- Reset release: the first edge with reset_n=1 and run=1 moves the block to F1.
- With zero-wait memory (mem_ready=1 in the first F2 cycle), the sequence is F1, F2, F3, DEC. exec_start is asserted in the 4th cycle after leaving IDLE.
- Each extra F2 cycle without mem_ready adds one cycle to that latency.
- Timeout: MEM_WAIT_MAX consecutive F2 cycles with mem_ready=0 lead to FAULT on the next edge. mem_ready arriving in F2 cycle number MEM_WAIT_MAX is still accepted.
- exec_done seen in EXEC leads to F1 on the next edge, so back-to-back instructions have a minimum period of 5 cycles.
- opcode is valid from the cycle after DEC until the next DEC.
- instr_count updates on the edge that leaves EXEC.

## Test plan
- Reset, then run=1, mem_ready=1 always, ir_in=16'h1234 (ADD), exec_done one cycle after exec_start -> strobes follow F1/F2/F3/DEC/EXEC; exec_start in cycle 4; opcode=4'h1; instr_count=1; F1 re-entered.
- mem_ready held 0 for 3 F2 cycles, then 1 -> ld_mdr is a single cycle, coinciding with mem_ready; exec_start in cycle 7.
- MEM_WAIT_MAX=4, mem_ready stuck 0 -> fault=1 after 4 F2 cycles; all strobes 0 thereafter; exec_start never seen.
- ir_in=16'hF025 -> halted=1 after DEC, no exec_start. ir_in=16'hA000 in a fresh run -> fault=1.
- run dropped during F2 -> instruction completes, instr_count increments, state IDLE with no new gate_pc. Then reset_n pulsed low in EXEC -> all outputs 0 immediately and instr_count=0.
- Preload 65535 retirements (or force the counter) -> the next exec_done wraps instr_count to 0.
